// File: rtl/rsa_operand_loader_if.sv
// Word-stream handshake into the rsa4k operand loader.
// The host side drives data, valid and last; the loader drives ready.
interface rsa_operand_loader_if #(
  parameter int WORD = 32
) ();
  logic [WORD-1:0] s_data;
  logic            s_valid;
  logic            s_last;
  logic            s_ready;

  modport master (
    output s_data,
    output s_valid,
    output s_last,
    input  s_ready
  );

  modport slave (
    input  s_data,
    input  s_valid,
    input  s_last,
    output s_ready
  );
endinterface

// File: rtl/rsa_operand_loader.sv
// Assembles message/exponent/modulus for rsa4k from a 32-bit word stream.
// Holds go as a level until done, then waits for done to fall before rearming.
module rsa_operand_loader #(
  parameter int WIDTH = 4096,
  parameter int WORD  = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  rsa_operand_loader_if.slave  s,
  output logic [WIDTH-1:0]     message,
  output logic [WIDTH-1:0]     exponent,
  output logic [WIDTH-1:0]     modulus,
  output logic                 go,
  input  logic                 done,
  output logic                 busy,
  output logic                 err
);
  localparam int NWORDS = WIDTH / WORD;
  localparam int CW     = $clog2(NWORDS);

  typedef enum logic [2:0] {
    LOAD_MSG,
    LOAD_EXP,
    LOAD_MOD,
    RUN,
    FLUSH
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] msg_q, msg_d;
  logic [WIDTH-1:0] exp_q, exp_d;
  logic [WIDTH-1:0] mod_q, mod_d;
  logic             go_q, go_d;
  logic             busy_q, busy_d;
  logic             err_q, err_d;
  logic             ready_q, ready_d;

  logic acc;
  logic last_w;
  logic final_w;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    msg_d   = msg_q;
    exp_d   = exp_q;
    mod_d   = mod_q;
    go_d    = go_q;
    busy_d  = busy_q;
    err_d   = 1'b0;
    ready_d = ready_q;
    acc     = s.s_valid && ready_q;
    last_w  = cnt_q == CW'(NWORDS - 1);
    final_w = (state_q == LOAD_MOD) && last_w;

    unique case (state_q)
      LOAD_MSG: if (acc) msg_d = {s.s_data, msg_q[WIDTH-1:WORD]};
      LOAD_EXP: if (acc) exp_d = {s.s_data, exp_q[WIDTH-1:WORD]};
      LOAD_MOD: if (acc) mod_d = {s.s_data, mod_q[WIDTH-1:WORD]};
      RUN: begin
        if (done) begin
          state_d = FLUSH;
          go_d    = 1'b0;
        end
      end
      FLUSH: begin
        if (!done) begin
          state_d = LOAD_MSG;
          cnt_d   = '0;
          busy_d  = 1'b0;
          ready_d = 1'b1;
        end
      end
      default: state_d = LOAD_MSG;
    endcase

    // s_last must coincide exactly with the final modulus word
    if (acc && (state_q != RUN) && (state_q != FLUSH)) begin
      if (s.s_last != final_w) begin
        err_d   = 1'b1;
        state_d = LOAD_MSG;
        cnt_d   = '0;
      end else begin
        cnt_d = last_w ? '0 : cnt_q + CW'(1);
        if (last_w) begin
          unique case (state_q)
            LOAD_MSG: state_d = LOAD_EXP;
            LOAD_EXP: state_d = LOAD_MOD;
            default: begin
              state_d = RUN;
              go_d    = 1'b1;
              busy_d  = 1'b1;
              ready_d = 1'b0;
            end
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= LOAD_MSG;
      cnt_q   <= '0;
      msg_q   <= '0;
      exp_q   <= '0;
      mod_q   <= '0;
      go_q    <= 1'b0;
      busy_q  <= 1'b0;
      err_q   <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      msg_q   <= msg_d;
      exp_q   <= exp_d;
      mod_q   <= mod_d;
      go_q    <= go_d;
      busy_q  <= busy_d;
      err_q   <= err_d;
      ready_q <= ready_d;
    end
  end

  assign s.s_ready = ready_q;
  assign message   = msg_q;
  assign exponent  = exp_q;
  assign modulus   = mod_q;
  assign go        = go_q;
  assign busy      = busy_q;
  assign err       = err_q;
endmodule

// File: tb/tb_rsa_operand_loader.sv
// Randomised scoreboard bench for rsa_operand_loader.
// Operand sets are queued on issue and checked when go rises.
module tb_rsa_operand_loader;
  localparam int WIDTH = 4096;
  localparam int WORD  = 32;
  localparam int NW    = WIDTH / WORD;

  typedef logic [WIDTH-1:0] op_t;
  typedef struct {
    op_t m;
    op_t e;
    op_t x;
  } set_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic done  = 1'b0;
  op_t  message, exponent, modulus;
  logic go, busy, err;

  int   checks  = 0;
  int   errors  = 0;
  set_t exp_q[$];
  int   err_exp = 0;
  logic go_p    = 1'b0;
  logic err_p   = 1'b0;

  rsa_operand_loader_if #(.WORD(WORD)) lif ();

  rsa_operand_loader #(
    .WIDTH(WIDTH),
    .WORD (WORD)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .s       (lif),
    .message (message),
    .exponent(exponent),
    .modulus (modulus),
    .go      (go),
    .done    (done),
    .busy    (busy),
    .err     (err)
  );

  always #5 clk = ~clk;

  task automatic chk_op(input string n, input op_t a, input op_t w);
    int k;
    checks++;
    if (a !== w) begin
      k = 0;
      for (int i = NW - 1; i >= 0; i--)
        if (a[i*WORD+:WORD] !== w[i*WORD+:WORD]) k = i;
      errors++;
      $display("FAIL %s: word %0d got %h want %h",
               n, k, a[k*WORD+:WORD], w[k*WORD+:WORD]);
    end
  endtask

  task automatic chk_int(input string n, input int a, input int w);
    checks++;
    if (a !== w) begin
      errors++;
      $display("FAIL %s: got %0d want %0d", n, a, w);
    end
  endtask

  function automatic op_t rand_op();
    op_t v;
    for (int i = 0; i < NW; i++) v[i*WORD+:WORD] = $urandom;
    return v;
  endfunction

  // monitor: operand sets on go rising, framing errors on err
  always @(negedge clk) begin
    if (go && !go_p) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL go_unexpected: got go=1 want no pending set");
      end else begin
        set_t sx;
        sx = exp_q.pop_front();
        chk_op("message", message, sx.m);
        chk_op("exponent", exponent, sx.e);
        chk_op("modulus", modulus, sx.x);
        chk_int("ready_in_run", int'(lif.s_ready), 0);
        chk_int("busy_in_run", int'(busy), 1);
      end
    end
    if (err) begin
      chk_int("err_one_cycle", int'(err_p), 0);
      chk_int("go_on_err", int'(go), 0);
      if (err_exp == 0) begin
        checks++;
        errors++;
        $display("FAIL err_unexpected: got err=1 want 0");
      end else begin
        err_exp--;
      end
    end
    go_p  = go;
    err_p = err;
  end

  // called at a negedge; returns at the negedge after the accept edge
  task automatic send(input logic [WORD-1:0] d, input logic l,
                      input bit gaps);
    if (gaps)
      while ($urandom_range(1, 0) == 0) begin
        lif.s_valid = 1'b0;
        lif.s_data  = $urandom;
        lif.s_last  = 1'b1;
        @(negedge clk);
      end
    lif.s_data  = d;
    lif.s_last  = l;
    lif.s_valid = 1'b1;
    if (!lif.s_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_in_load: got s_ready=0 want 1");
    end
    @(negedge clk);
    lif.s_valid = 1'b0;
    lif.s_last  = 1'b0;
  endtask

  task automatic load_set(input op_t m, input op_t e, input op_t x,
                          input bit gaps, input bit good);
    set_t sx;
    sx.m = m;
    sx.e = e;
    sx.x = x;
    if (good) exp_q.push_back(sx);
    else err_exp++;
    for (int i = 0; i < NW; i++) send(m[i*WORD+:WORD], 1'b0, gaps);
    for (int i = 0; i < NW; i++) send(e[i*WORD+:WORD], 1'b0, gaps);
    for (int i = 0; i < NW; i++)
      send(x[i*WORD+:WORD], (i == NW - 1) ? good : 1'b0, gaps);
    chk_int(good ? "go_after_last" : "go_after_bad_last",
            int'(go), good ? 1 : 0);
  endtask

  task automatic finish_run();
    done = 1'b1;
    @(negedge clk);
    chk_int("go_after_done", int'(go), 0);
    chk_int("busy_flush", int'(busy), 1);
    chk_int("ready_flush", int'(lif.s_ready), 0);
    repeat (3) @(negedge clk);
    chk_int("busy_held_flush", int'(busy), 1);
    done = 1'b0;
    @(negedge clk);
    chk_int("ready_rearm", int'(lif.s_ready), 1);
    chk_int("busy_rearm", int'(busy), 0);
  endtask

  initial begin
    op_t m, e, x;
    lif.s_data  = '0;
    lif.s_valid = 1'b0;
    lif.s_last  = 1'b0;

    #1 reset = 1'b0;
    #1;
    chk_op("reset_message", message, '0);
    chk_op("reset_exponent", exponent, '0);
    chk_op("reset_modulus", modulus, '0);
    chk_int("reset_go", int'(go), 0);
    chk_int("reset_busy", int'(busy), 0);
    chk_int("reset_err", int'(err), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_int("ready_after_reset", int'(lif.s_ready), 1);

    // directed set, no gaps
    load_set(op_t'(8), op_t'(13), op_t'(77), 1'b0, 1'b1);

    // junk while running must not be taken
    for (int i = 0; i < 8; i++) begin
      lif.s_valid = 1'b1;
      lif.s_data  = $urandom;
      lif.s_last  = 1'($urandom);
      @(negedge clk);
    end
    lif.s_valid = 1'b0;
    lif.s_last  = 1'b0;
    chk_op("run_hold_message", message, op_t'(8));
    chk_op("run_hold_exponent", exponent, op_t'(13));
    chk_op("run_hold_modulus", modulus, op_t'(77));
    finish_run();

    // back-to-back second set
    load_set(op_t'(32'h32), op_t'(37), op_t'(77), 1'b0, 1'b1);
    finish_run();

    // done while loading is ignored
    done = 1'b1;
    repeat (2) @(negedge clk);
    done = 1'b0;
    @(negedge clk);
    chk_int("done_in_load_go", int'(go), 0);
    chk_int("done_in_load_busy", int'(busy), 0);
    chk_int("done_in_load_ready", int'(lif.s_ready), 1);

    // same directed set with random valid gaps
    load_set(op_t'(8), op_t'(13), op_t'(77), 1'b1, 1'b1);
    finish_run();

    // random full-width sets with gaps
    for (int k = 0; k < 2; k++) begin
      m = rand_op();
      e = rand_op();
      x = rand_op();
      load_set(m, e, x, 1'b1, 1'b1);
      finish_run();
    end

    // early s_last on the last message word
    err_exp++;
    m = rand_op();
    for (int i = 0; i < NW; i++)
      send(m[i*WORD+:WORD], (i == NW - 1), 1'b1);
    chk_int("go_after_early_last", int'(go), 0);
    @(negedge clk);
    chk_int("err_cleared", int'(err), 0);
    load_set(rand_op(), rand_op(), rand_op(), 1'b1, 1'b1);
    finish_run();

    // missing s_last on the final modulus word
    load_set(rand_op(), rand_op(), rand_op(), 1'b0, 1'b0);
    load_set(op_t'(32'h32), op_t'(37), op_t'(77), 1'b0, 1'b1);

    // asynchronous reset while running
    #2 reset = 1'b0;
    #1;
    chk_int("async_reset_go", int'(go), 0);
    chk_int("async_reset_busy", int'(busy), 0);
    chk_op("async_reset_message", message, '0);
    chk_op("async_reset_modulus", modulus, '0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk_int("ready_after_mid_reset", int'(lif.s_ready), 1);
    load_set(rand_op(), rand_op(), rand_op(), 1'b1, 1'b1);
    finish_run();

    repeat (4) @(negedge clk);
    chk_int("sets_pending", exp_q.size(), 0);
    chk_int("errs_pending", err_exp, 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/rsa_operand_loader.md
Name: rsa_operand_loader

Overview:
- Upstream feeder for rsa4k.
- Assembles the 4096-bit message, exponent and modulus operands from a 32-bit valid/ready word stream.
- Drives rsa4k go as a level and holds operands stable until rsa4k asserts done.
- Rearms for the next operand set after done drops.
- Sits between the host/bus word interface and the rsa4k core.

Parameters:
- WIDTH, 4096, operand width in bits; must be a multiple of WORD.
- WORD, 32, stream word width in bits.
- NWORDS, WIDTH/WORD (128), words per operand; derived, not overridable.

Ports:
- clk  in  1  core clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset.
- s_data  in  WORD  stream word.
- s_valid  in  1  s_data valid.
- s_last  in  1  marks the final word of the modulus (word 383 of the set).
- s_ready  out  1  loader accepts a word this cycle.
- message  out  WIDTH  to rsa4k.message.
- exponent  out  WIDTH  to rsa4k.exponent.
- modulus  out  WIDTH  to rsa4k.modulus.
- go  out  1  to rsa4k.go; level.
- done  in  1  from rsa4k.done.
- busy  out  1  high in RUN and FLUSH.
- err  out  1  one-cycle framing-error pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=LOAD_MSG, word counter=0.
  - message/exponent/modulus=0; go=0, busy=0, err=0.
  - s_ready=1 from the first cycle after reset deasserts.
  - Reset mid-RUN drops go immediately (asynchronous).
- Transfer rule:
  - A word is accepted on a rising edge with s_valid&&s_ready.
  - No acceptance without both; s_data is ignored otherwise.
- Word order: each operand is sent least-significant word first. The stream order is message, then exponent, then modulus.
- Load mechanism: the selected operand register shifts right by WORD with s_data entering at [WIDTH-1:WIDTH-WORD]. After NWORDS accepts, word 0 sits at [WORD-1:0].
- Counter: 7-bit (log2 NWORDS) word counter increments per accept and wraps to 0 at NWORDS-1.
- State machine:
  - LOAD_MSG: s_ready=1. On the 128th accept -> LOAD_EXP.
  - LOAD_EXP: s_ready=1. On the 128th accept -> LOAD_MOD.
  - LOAD_MOD: s_ready=1.
    - On the 128th accept with s_last=1 -> RUN. go rises in the cycle after that accept.
    - On the 128th accept with s_last=0 -> framing error.
  - RUN: s_ready=0, go=1, busy=1, operands frozen.
    - On done=1 sampled -> FLUSH, with go=0 from the next cycle.
  - FLUSH: s_ready=0, go=0, busy=1. Waits for done=0, then -> LOAD_MSG with counter=0.
- Latency: last modulus accept at edge N -> go=1 after edge N. done seen at edge M -> go=0 after edge M.
- Framing error:
  - Triggers: s_last=1 on any accepted word other than the final modulus word, or s_last=0 on that final word.
  - Response: err=1 for exactly one cycle; state -> LOAD_MSG; counter=0; go stays 0.
  - Operand registers keep partial contents; they are irrelevant because go is not asserted.
- done=1 while in a LOAD state is ignored.
- done already high on entry to FLUSH: FLUSH is held until done falls.
- Operands change only on accepts in their own LOAD state. They are stable throughout RUN and FLUSH and across the next load until overwritten.
- s_ready is registered and depends on state only, never on s_valid.

Test Plan:
- Reset, then stream message=8, exponent=13 (0xD), modulus=77 (0x4D) as 3×128 words LSW first, s_last on word 383.
  -> message=8, exponent=0xD, modulus=0x4D.
  -> go=1 the cycle after the last accept; s_ready=0, busy=1.
  -> With rsa4k attached: done, and cypher=0x32.
- Same load with random s_valid gaps (~50%).
  -> Identical operand values; no word lost or duplicated; s_ready never low in LOAD states.
- In RUN, hold s_valid=1 with junk data.
  -> No accept; operands unchanged.
  -> done pulse -> go=0 next cycle; FLUSH until done=0; then s_ready=1.
- Second set (message=0x32, exponent=37, modulus=77) back-to-back after done.
  -> Operands updated to new values; go reasserts only after the final modulus word.
- s_last asserted on word 127 (last message word).
  -> err pulses for 1 cycle; go stays 0; next word is accepted as message word 0.
- Assert reset low mid-RUN.
  -> go=0, busy=0, operands=0 asynchronously; after release, s_ready=1 and loading restarts at message word 0.
